// File: rtl/riscv_if_queued.sv
// riscv_if_queued: instruction-fetch stage with a decoupling fetch queue.
// Owns the fetch PC, accepts aligned packets from the realigner (following
// the predictor's redirect/target decision) and buffers them in a DEPTH-entry
// circular queue. Decode drains the queue through a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   fetch_pc            current fetch PC (registered)
//   in_valid/in_inst/in_compressed   aligned packet from the realigner
//   pred_redirect/pred_target        qualified predictor decision
//   in_accept           packet accepted this cycle (combinational)
//   make_correction/pc_correction    EX redirect, flushes the queue
//   out_valid/out_ready handshake towards decode
//   out_inst/out_pc/out_compressed/out_pred_dest   queue head (NOP/0 when empty)
//   occupancy           entries held
//   full_stall_cnt      saturating count of cycles a packet was refused
module riscv_if_queued #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [XLEN-1:0]          fetch_pc,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_inst,
    input  logic                     in_compressed,
    input  logic                     pred_redirect,
    input  logic [XLEN-1:0]          pred_target,
    output logic                     in_accept,
    input  logic                     make_correction,
    input  logic [XLEN-1:0]          pc_correction,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_inst,
    output logic [XLEN-1:0]          out_pc,
    output logic                     out_compressed,
    output logic [XLEN-1:0]          out_pred_dest,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              full_stall_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Queue storage, one array per packet field.
    logic [XLEN-1:0]  mem_pc   [DEPTH];
    logic [XLEN-1:0]  mem_inst [DEPTH];
    logic [XLEN-1:0]  mem_dest [DEPTH];
    logic [DEPTH-1:0] mem_comp;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic             stall_c;
    logic [XLEN-1:0]  next_pc_c;

    // Handshake and next-PC decisions.
    always_comb begin
        empty_c   = (count == '0);
        full_c    = (count == CNT_W'(DEPTH));
        pop_c     = !empty_c && out_ready && !make_correction;
        push_c    = in_valid && !make_correction && (!full_c || pop_c);
        stall_c   = in_valid && !push_c && !make_correction;
        next_pc_c = pred_redirect ? pred_target
                                  : fetch_pc + (in_compressed ? XLEN'(2) : XLEN'(4));
    end

    // Head view; fields are forced to NOP/0 while the queue is empty.
    always_comb begin
        in_accept      = push_c;
        out_valid      = !empty_c;
        out_inst       = NOP;
        out_pc         = '0;
        out_compressed = 1'b0;
        out_pred_dest  = '0;
        occupancy      = count;
        if (!empty_c) begin
            out_inst       = mem_inst[rd_ptr];
            out_pc         = mem_pc[rd_ptr];
            out_compressed = mem_comp[rd_ptr];
            out_pred_dest  = mem_dest[rd_ptr];
        end
    end

    // Fetch PC: correction beats an accepted packet, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (make_correction) begin
            fetch_pc <= pc_correction;
        end else if (push_c) begin
            fetch_pc <= next_pc_c;
        end
    end

    // Pointers and occupancy; a correction flushes and drops same-cycle traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (make_correction) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + CNT_W'(1);
            end else if (!push_c && pop_c) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry write; stale contents are harmless because count gates the head.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_pc[wr_ptr]   <= fetch_pc;
            mem_inst[wr_ptr] <= in_inst;
            mem_comp[wr_ptr] <= in_compressed;
            mem_dest[wr_ptr] <= next_pc_c;
        end
    end

    // Refused-packet counter, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_stall_cnt <= '0;
        end else if (stall_c && (full_stall_cnt != '1)) begin
            full_stall_cnt <= full_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_riscv_if_queued.sv
// tb_riscv_if_queued: scoreboard bench for riscv_if_queued. A driver issues
// directed and random packets and steps a queue-level reference model; a
// separate monitor compares every packet decode consumes against the
// expected-packet queue.
module tb_riscv_if_queued;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        in_compressed;
    logic        pred_redirect;
    logic [31:0] pred_target;
    logic        in_accept;
    logic        make_correction;
    logic [31:0] pc_correction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_compressed;
    logic [31:0] out_pred_dest;
    logic [2:0]  occupancy;
    logic [31:0] full_stall_cnt;

    riscv_if_queued #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .in_valid(in_valid), .in_inst(in_inst), .in_compressed(in_compressed),
        .pred_redirect(pred_redirect), .pred_target(pred_target),
        .in_accept(in_accept),
        .make_correction(make_correction), .pc_correction(pc_correction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_compressed(out_compressed),
        .out_pred_dest(out_pred_dest), .occupancy(occupancy),
        .full_stall_cnt(full_stall_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        comp;
        logic [31:0] dest;
    } pkt_t;

    pkt_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;

    // Reference model state.
    logic [31:0] m_pc;
    int          m_count;
    logic [31:0] m_stall;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every real consume of the head must match the oldest expected packet.
    initial begin
        pkt_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !make_correction) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL head_spurious: got pc %h with no packet expected at %0t", out_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_pc", out_pc, e.pc);
                    chk("head_inst", out_inst, e.inst);
                    chk("head_comp", 32'(out_compressed), 32'(e.comp));
                    chk("head_dest", out_pred_dest, e.dest);
                end
            end
        end
    end

    // Compare visible state against the model, then advance the model by the coming edge.
    task automatic model_check();
        logic        pop_m;
        logic        acc_m;
        logic [31:0] nxt;
        chk("fetch_pc", fetch_pc, m_pc);
        chk("occupancy", 32'(occupancy), 32'(m_count));
        chk("out_valid", 32'(out_valid), 32'(m_count != 0));
        chk("stall_cnt", full_stall_cnt, m_stall);
        if (m_count == 0) begin
            chk("empty_inst", out_inst, NOP);
            chk("empty_pc", out_pc, 32'h0);
            chk("empty_dest", out_pred_dest, 32'h0);
            chk("empty_comp", 32'(out_compressed), 32'h0);
        end
        pop_m = (m_count != 0) && out_ready && !make_correction;
        acc_m = in_valid && !make_correction && ((m_count < DEPTH) || pop_m);
        chk("in_accept", 32'(in_accept), 32'(acc_m));
        if (in_valid && !acc_m && !make_correction && m_stall != 32'hFFFF_FFFF)
            m_stall = m_stall + 32'd1;
        nxt = pred_redirect ? pred_target : m_pc + (in_compressed ? 32'd2 : 32'd4);
        if (make_correction) begin
            m_count = 0;
            exp_q.delete();
            m_pc = pc_correction;
        end else begin
            if (acc_m) begin
                exp_q.push_back('{pc: m_pc, inst: in_inst, comp: in_compressed, dest: nxt});
                m_pc = nxt;
            end
            m_count = m_count + int'(acc_m) - int'(pop_m);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] inst, input logic c,
                        input logic rd, input logic [31:0] tgt,
                        input logic mc, input logic [31:0] mcpc, input logic rdy);
        @(posedge clk);
        #1;
        in_valid        = v;
        in_inst         = inst;
        in_compressed   = c;
        pred_redirect   = rd;
        pred_target     = tgt;
        make_correction = mc;
        pc_correction   = mcpc;
        out_ready       = rdy;
        @(negedge clk);
        #1;
        model_check();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic fetch(input logic c, input logic rdy);
        step(1'b1, $urandom, c, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    task automatic correct(input logic [31:0] pc);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, pc, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0; in_inst = '0; in_compressed = 1'b0;
        pred_redirect = 1'b0; pred_target = '0;
        make_correction = 1'b0; pc_correction = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_pc    = RESET_PC;
        m_count = 0;
        m_stall = 32'h0;
        exp_q.delete();
        @(negedge clk);
        #1;
        chk("rst_fetch_pc", fetch_pc, RESET_PC);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_inst", out_inst, NOP);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_stall_cnt", full_stall_cnt, 32'h0);
        chk("rst_in_accept", 32'(in_accept), 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] t;
        rst_n = 1'b0;
        in_valid = 1'b0; in_inst = '0; in_compressed = 1'b0;
        pred_redirect = 1'b0; pred_target = '0;
        make_correction = 1'b0; pc_correction = '0; out_ready = 1'b0;

        do_reset();

        // Streaming 4-byte packets with decode always ready.
        for (int i = 0; i < 3; i++) fetch(1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        idle();

        // Back-pressure: fill the queue, two refused packets.
        do_reset();
        for (int i = 0; i < 6; i++) fetch(1'b0, 1'b0);
        idle();
        chk("plan_stall_cnt", full_stall_cnt, 32'd2);
        chk("plan_full_occ", 32'(occupancy), 32'd4);
        fetch(1'b0, 1'b1);
        // Full queue, pop cycle with a predicted redirect.
        step(1'b1, $urandom, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 1'b1);
        idle();
        chk("plan_redir_pc", fetch_pc, 32'h0000_0200);
        chk("plan_redir_occ", 32'(occupancy), 32'd4);
        for (int i = 0; i < 5; i++)
            step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // RVC followed by a 4-byte instruction, then a flush with traffic.
        correct(32'h0000_0010);
        fetch(1'b1, 1'b0);
        fetch(1'b0, 1'b0);
        fetch(1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0080, 1'b1);
        idle();
        chk("plan_flush_occ", 32'(occupancy), 32'd0);
        chk("plan_flush_inst", out_inst, NOP);
        chk("plan_flush_pc", fetch_pc, 32'h0000_0080);

        // PC wrap on a compressed instruction.
        correct(32'hFFFF_FFFE);
        fetch(1'b1, 1'b1);
        idle();
        chk("plan_pc_wrap", fetch_pc, 32'h0000_0000);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Two entries held at fetch_pc 0x40, then reset mid-operation.
        correct(32'h0000_0038);
        fetch(1'b0, 1'b0);
        fetch(1'b0, 1'b0);
        idle();
        chk("plan_pre_rst_pc", fetch_pc, 32'h0000_0040);
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            r = $urandom;
            t = $urandom;
            t[0] = 1'b0;
            step(($urandom_range(0, 3) != 0), $urandom, r[0], (r[3:1] == 3'd0), t,
                 (r[8:4] == 5'd0), {t[31:1] ^ r[31:1], 1'b0}, (r[11:9] > 3'd2));
        end
        for (int i = 0; i < DEPTH + 2; i++)
            step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_if_queued.md
# riscv_if_queued

Parametrised instruction-fetch stage with a decoupling fetch queue. It owns the fetch PC and accepts aligned instruction packets from the realigner, using the predictor's combined taken/target decision. Accepted packets {pc, inst, compressed, pred_dest} go into a DEPTH-entry circular queue, and decode drains the queue through a valid/ready handshake. This absorbs ID back-pressure without stalling the instruction cache and replaces the single IF/ID register of the previous generation.

## Interface
Parameters:
- XLEN, 32: PC and instruction width.
- DEPTH, 4: queue entries. Power of two, ≥ 2.
- RESET_PC, 0: fetch PC after reset.
- NOP, 32'h00000013: instruction driven when the queue is empty.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- fetch_pc  out  XLEN  current fetch PC (registered), to the realigner and predictor.
- in_valid  in  1  realigner has an aligned instruction for fetch_pc.
- in_inst  in  XLEN  aligned instruction. Upper half is don't-care when compressed.
- in_compressed  in  1  instruction is RVC.
- pred_redirect  in  1  predictor redirect, already qualified by the source: (taken && branch) || jump.
- pred_target  in  XLEN  predicted target.
- in_accept  out  1  packet accepted this cycle (combinational).
- make_correction  in  1  EX misprediction or redirect.
- pc_correction  in  XLEN  corrected PC.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode consumes the head (= !stall).
- out_inst  out  XLEN  head instruction, or NOP when empty.
- out_pc  out  XLEN  head PC, 0 when empty.
- out_compressed  out  1  head RVC flag, 0 when empty.
- out_pred_dest  out  XLEN  PC that fetch followed after the head instruction, 0 when empty.
- occupancy  out  clog2(DEPTH)+1  entries held.
- full_stall_cnt  out  32  saturating count of cycles with in_valid && !in_accept && !make_correction.

## Operation
- Storage: DEPTH-entry array with rd_ptr and wr_ptr of clog2(DEPTH) bits each, wrapping modulo DEPTH. The count register is the occupancy. empty = (count==0), full = (count==DEPTH).
- pop = out_valid && out_ready && !make_correction.
- in_accept = in_valid && !make_correction && (!full || pop). A push is therefore allowed when the queue is full and a pop happens in the same cycle.
- next_pc = pred_redirect ? pred_target : fetch_pc + (in_compressed ? 2 : 4), modulo 2^XLEN.
- Push writes {fetch_pc, in_inst, in_compressed, next_pc} at wr_ptr.
- fetch_pc update, in priority order:
  - make_correction: pc_correction.
  - in_accept: next_pc.
  - otherwise: hold.
- Count update:
  - make_correction: count, rd_ptr and wr_ptr all reset to 0. The queue is flushed, and any push or pop in that cycle is discarded.
  - Otherwise: count += push − pop. Push and pop together leave count unchanged.
- Head outputs are driven combinationally from entry[rd_ptr], gated by out_valid = !empty. When empty they show NOP / 0 / 0 / 0.
- full_stall_cnt increments when in_valid && !in_accept && !make_correction. It saturates at 2^32−1 and clears only on reset.
- pred_redirect and pred_target are ignored when in_valid=0.

## Timing
- Reset (rst_n=0 at an edge): fetch_pc=RESET_PC, count=0, pointers=0, full_stall_cnt=0. Outputs after reset: out_valid=0, out_inst=NOP, out_pc=0, out_compressed=0, out_pred_dest=0, occupancy=0, in_accept=0 unless in_valid. Reset mid-operation discards all entries.
- Fetch-to-decode latency: a packet accepted at edge N is visible at the head in the cycle after edge N if the queue was empty. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle. A full queue with continuous pop sustains one instruction per cycle.
- Redirect: with make_correction at edge N, fetch_pc=pc_correction after N and out_valid=0 after N. The first corrected instruction can reach the head after edge N+1.
- Pointer wrap: wr_ptr DEPTH−1 → 0 and rd_ptr DEPTH−1 → 0 without a bubble.
- PC wrap: 0xFFFFFFFE + 2 → 0x00000000.

## Test plan
- Reset, then a 4-byte non-branch stream with out_ready=1 and in_valid=1 from PC 0: heads 0, 4, 8 appear with out_pred_dest 4, 8, 12, occupancy stays ≤ 1, and full_stall_cnt=0.
- out_ready=0 with DEPTH=4 and 6 offered packets: occupancy reaches 4, in_accept drops, and full_stall_cnt=2 after 6 cycles. Releasing out_ready then drains PCs 0, 4, 8, 12 in order and accepts the next packet on the first pop cycle.
- RVC at 0x10 then a 4-byte instruction: entries pc=0x10/pred_dest=0x12 and pc=0x12/pred_dest=0x16.
- Full queue, in_valid=1, and pred_redirect=1 with target 0x200 on the pop cycle: the packet is accepted, count stays 4, and fetch_pc becomes 0x200.
- Three entries queued, make_correction=1 with pc_correction 0x80 together with in_valid=1 and out_ready=1: next cycle occupancy=0, out_inst=NOP and fetch_pc=0x80. The dropped packet never appears at the head.
- rst_n=0 asserted with 2 entries held and fetch_pc=0x40: next cycle fetch_pc=RESET_PC, out_valid=0 and full_stall_cnt=0.
